// File: rtl/mdu_defs_pkg.sv
// Shared MDU definitions: op encodings, FSM states and op-class masks.
// The divide op mask depends on the MDU_DIV_EN build macro.
package mdu_defs_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Bit n of a mask is set when op encoding n belongs to that class.
    localparam logic [15:0] MULT_OP_MASK = 16'h0006;
`ifdef MDU_DIV_EN
    localparam logic [15:0] DIV_OP_MASK  = 16'h0018;
`else
    localparam logic [15:0] DIV_OP_MASK  = 16'h0000;
`endif

    function automatic logic op_in_mask(input logic [15:0] mask, input logic [3:0] op);
        return mask[op];
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath feeding the mdu_ctrl result latch.
// Divider is present only when MDU_DIV_EN is defined.
module mdu_arith
    import mdu_defs_pkg::*;
(
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        divzero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic        div_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    always_comb begin
        div_signed = (mdu_op == OP_DIV);
        abs_a      = (div_signed && a[31]) ? 32'(~a + 32'd1) : a;
        abs_b      = (div_signed && b[31]) ? 32'(~b + 32'd1) : b;
        safe_b     = (b == 32'd0) ? 32'd1 : abs_b;
        uq         = abs_a / safe_b;
        ur         = abs_a % safe_b;
        q          = (div_signed && (a[31] ^ b[31])) ? 32'(~uq + 32'd1) : uq;
        r          = (div_signed && a[31]) ? 32'(~ur + 32'd1) : ur;
    end
`endif

    always_comb begin
        res     = 64'd0;
        divzero = 1'b0;
        case (mdu_op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                res     = {r, q};
                divzero = (b == 32'd0);
            end
`endif
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; Busy is a registered state decode.
// DIV/DIVU exist only in builds with MDU_DIV_EN defined.
module mdu_ctrl
    import mdu_defs_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output mdu_state_e  dbg_state
);

    // Handshake: Start is the valid for MDUOp/A/B; ~Busy is the ready. An op is
    // taken on a rising edge where Start & ~Req & ~Busy; otherwise it is dropped.
    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        wr_q, wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] arith_res;
    logic        arith_divzero;
    logic        accept;
    logic        is_mult;
    logic        is_div;

    mdu_arith u_arith (
        .mdu_op  (MDUOp),
        .a       (A),
        .b       (B),
        .res     (arith_res),
        .divzero (arith_divzero)
    );

    assign accept  = Start & ~Req & (state_q == ST_IDLE);
    assign is_mult = op_in_mask(MULT_OP_MASK, MDUOp);
    assign is_div  = op_in_mask(DIV_OP_MASK, MDUOp);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mult || is_div) begin
                        res_d   = arith_res;
                        wr_d    = ~arith_divzero;
                        cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state_d = ST_RUN;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Last busy cycle: commit unless the divisor was zero.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            wr_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy      = (state_q == ST_RUN);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl; divide expectations follow the MDU_DIV_EN build.
module tb_mdu_ctrl;
    import mdu_defs_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    mdu_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DIV_BUSY = DIV_ON ? 10 : 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .MDUOp     (MDUOp),
        .A         (A),
        .B         (B),
        .Req       (Req),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers: present an op for one cycle starting at a falling edge; return
    // at the next falling edge, i.e. the first cycle after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        Req   = req;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NONE;
        Req   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_hi"}, {32'd0, HI}, {32'd0, hi});
        check({tag, "_lo"}, {32'd0, LO}, {32'd0, lo});
    endtask

    initial begin
        int n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;

        reset = 1'b1;
        Start = 1'b0;
        MDUOp = OP_NONE;
        A     = 32'd0;
        B     = 32'd0;
        Req   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
        check_hilo("reset", 32'd0, 32'd0);

        // Signed multiply: -2 * 3 = -6
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_busy_first", {63'd0, Busy}, 64'd1);
        check_hilo("mult_inflight", 32'd0, 32'd0);
        wait_idle(n);
        check("mult_busy_len", 64'(n), 64'd5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFA;

        // Signed divide: -7 / 2 = -3 rem -1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        check("div_busy_len", 64'(n), 64'(DIV_BUSY));
        if (DIV_ON) begin
            exp_hi = 32'hFFFF_FFFF;
            exp_lo = 32'hFFFF_FFFD;
        end
        check_hilo("div", exp_hi, exp_lo);

        // Unsigned divide on the same operands
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        check("divu_busy_len", 64'(n), 64'(DIV_BUSY));
        if (DIV_ON) begin
            exp_hi = 32'd1;
            exp_lo = 32'h7FFF_FFFC;
        end
        check_hilo("divu", exp_hi, exp_lo);

        // MTHI / MTLO take effect the next cycle without going busy
        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        check("mthi_busy", {63'd0, Busy}, 64'd0);
        check("mthi_hi", {32'd0, HI}, 64'h1234);
        issue(OP_MTLO, 32'h5678, 32'd0, 1'b0);
        check_hilo("mtlo", 32'h1234, 32'h5678);

        // Divide by zero runs full latency but leaves HI/LO alone
        issue(OP_DIV, 32'd100, 32'd0, 1'b0);
        wait_idle(n);
        check("divzero_busy_len", 64'(n), 64'(DIV_BUSY));
        check_hilo("divzero", 32'h1234, 32'h5678);

        // Signed overflow case must not trap
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        check("divovf_busy_len", 64'(n), 64'(DIV_BUSY));
        exp_hi = 32'h1234;
        exp_lo = 32'h5678;
        if (DIV_ON) begin
            exp_hi = 32'd0;
            exp_lo = 32'h8000_0000;
        end
        check_hilo("divovf", exp_hi, exp_lo);

        // Req in the accept cycle suppresses the op
        issue(OP_MULTU, 32'd9, 32'd9, 1'b1);
        check("req_suppress_busy", {63'd0, Busy}, 64'd0);
        @(negedge clk);
        check_hilo("req_suppress", exp_hi, exp_lo);

        // Req mid-run is ignored
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_busy_first", {63'd0, Busy}, 64'd1);
        @(negedge clk);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        wait_idle(n);
        check("multu_req_busy_len", 64'(n + 2), 64'd5);
        check_hilo("multu_req", 32'hFFFF_FFFE, 32'h0000_0001);

        // Back-to-back: accept in the first idle cycle
        issue(OP_MULT, 32'd7, 32'd6, 1'b0);
        check("b2b_busy_first", {63'd0, Busy}, 64'd1);
        wait_idle(n);
        check("b2b_busy_len", 64'(n), 64'd5);
        check_hilo("b2b", 32'd0, 32'd42);

        // Unknown ops have no effect
        issue(4'd7, 32'hDEAD, 32'hBEEF, 1'b0);
        check("unknown7_busy", {63'd0, Busy}, 64'd0);
        issue(4'd15, 32'hDEAD, 32'hBEEF, 1'b0);
        check("unknown15_busy", {63'd0, Busy}, 64'd0);
        check_hilo("unknown", 32'd0, 32'd42);

        // Reset in cycle 3 of a long op discards it
        issue(DIV_ON ? OP_DIV : OP_MULT, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {63'd0, Busy}, 64'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        repeat (15) @(negedge clk);
        check("rst_late_busy", {63'd0, Busy}, 64'd0);
        check_hilo("rst_late", 32'd0, 32'd0);

        // Multiply unaffected after reset
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_idle(n);
        check("post_rst_busy_len", 64'(n), 64'd5);
        check_hilo("post_rst", 32'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, holds operands, and counts a fixed latency. Commits the 64-bit result to the HI/LO registers and exports `Busy` so the hazard unit stalls later HI/LO-touching instructions in D. It also honours the exception request line (`Req`) so that an interrupted instruction never starts.

## Interface

- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Start` input 1: the E-stage instruction is an MDU op; qualifies `MDUOp`.
- `MDUOp` input 4: operation select; encodings are in the shared defs.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `Req` input 1: exception or interrupt taken this cycle; suppresses `Start`.
- `Busy` output 1: a multiply or divide is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation

- **Accept condition:** an op is accepted when `Start & ~Req & ~Busy`.
  - With `Start` and `Busy` both high, the op is ignored. The hazard unit guarantees this cannot occur.
- **States:**
  - `IDLE`: `Busy`=0.
  - `RUN`: `Busy`=1. A 4-bit down-counter `cnt` holds the remaining cycles.
- **IDLE, MULT/MULTU accepted:**
  - Latch the signed or unsigned 64-bit product of A and B into `res`.
  - Load `cnt` = MULT_CYCLES.
  - Go to `RUN`.
- **IDLE, DIV/DIVU accepted:**
  - Latch quotient → `res[31:0]` and remainder → `res[63:32]`, signed or unsigned.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Load `cnt` = DIV_CYCLES.
  - Go to `RUN`.
- **Divide by zero:** when B==0 the op is accepted and runs the full latency, but HI/LO stay unchanged at completion.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF must not trap. It gives LO=0x80000000, HI=0.
- **MTHI/MTLO accepted:**
  - HI←A or LO←A at this edge.
  - No `RUN`; `Busy` stays 0.
- **RUN:**
  - `cnt` decrements each cycle.
  - On the cycle with `cnt`==1: HI←`res[63:32]` and LO←`res[31:0]` at that edge, then return to `IDLE`.
- **Unknown `MDUOp` with `Start`:** no effect.
- **`Req` while in `RUN`:** ignored. The in-flight op was committed before the exception and completes normally.
- **Reset:** takes priority over everything. HI=0, LO=0, `Busy`=0, `cnt`=0, state `IDLE`. Any in-flight op is discarded.

## Timing

- **Multiply:** accept at edge T.
  - `Busy`=1 during cycles T+1 .. T+MULT_CYCLES.
  - New HI/LO visible and `Busy`=0 from cycle T+MULT_CYCLES+1.
- **Divide:** same as multiply, with DIV_CYCLES.
- **MTHI/MTLO:** new value visible the cycle after the accept edge.
- **Busy source:** `Busy` is registered and depends only on state. There is no combinational path from `Start` to `Busy`.
  - The hazard unit stalls on `Busy | Start`.
- **Back-to-back ops:** a new op can be accepted in the first cycle with `Busy`=0.

## Configuration

- **`MDU_DIV_EN` defined:** DIV/DIVU are implemented as described above.
- **`MDU_DIV_EN` undefined:**
  - The divider logic is removed.
  - DIV/DIVU are treated as unknown ops: no state change and `Busy` stays 0.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Structure

- **Shared defs include, `mdu_defs`:**
  - `MDUOp` encodings: MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Value 0 = none.
  - State encodings.
  - `DIV_EN`-dependent op masks.
- **Sub-module `mdu_arith`:**
  - Combinational; takes (`MDUOp`, A, B) and returns the 64-bit `res` plus a `divzero` flag.
  - The `MDU_DIV_EN` guard lives inside it.
- **`mdu_ctrl` itself:** owns the FSM, `cnt`, `res`, HI and LO.

## Test plan

- **Signed multiply:** reset, then MULT with A=0xFFFFFFFE, B=3.
  - `Busy`=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Signed divide:** DIV with A=0xFFFFFFF9 (−7), B=2.
  - `Busy`=1 for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with DIVU on the same operands: LO=0x7FFFFFFC, HI=1.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, then DIV with B=0.
  - `Busy` for 10 cycles.
  - HI=0x1234 and LO=0x5678 unchanged.
- **Req suppression:** MULTU with `Req`=1 in the same cycle.
  - `Busy` stays 0 and HI/LO are unchanged.
  - Next, issue MULTU 0xFFFFFFFF×0xFFFFFFFF with `Req`=0, then pulse `Req` mid-run.
  - The op completes: HI=0xFFFFFFFE, LO=0x00000001.
- **Reset mid-run:** assert `reset` in cycle 3 of a DIV.
  - Next cycle: `Busy`=0, HI=0, LO=0.
  - No late write to HI/LO occurs afterwards.
- **Build without `MDU_DIV_EN`:** issue DIV.
  - `Busy` stays 0 and HI/LO are unchanged.
  - MULT still takes 5 cycles.
